// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and derived totals.
// The pixel generator also takes MAX_X/MAX_Y from here.
package vga_timing_pkg;

    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    localparam int unsigned H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned MAX_X = H_VIS_DEF - 1;
    localparam int unsigned MAX_Y = V_VIS_DEF - 1;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] coord_t;

    // True when lo <= pos < hi.
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        in_window = (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with enable, look-ahead next value and wrap strobe.
// Out-of-range states fold back to zero on the next enabled edge.
module mod_counter #(
    parameter int unsigned MOD  = 800,
    parameter int unsigned W    = 10,
    parameter int unsigned INIT = 799
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;
    logic         wrap_s;

    // Next-count and wrap decode.
    always_comb begin
        count_next_s = count_r;
        wrap_s       = 1'b0;
        if (en) begin
            if (count_r >= LAST) begin
                count_next_s = {W{1'b0}};
                wrap_s       = 1'b1;
            end else begin
                count_next_s = count_r + W'(1);
                wrap_s       = 1'b0;
            end
        end else begin
            count_next_s = count_r;
            wrap_s       = 1'b0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= W'(INIT);
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;
    assign wrap       = wrap_s;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel counters, registered visibility/start flags,
// and sync outputs delayed one clock to line up with the registered colour stage.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS  = H_VIS_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_VIS  = V_VIS_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF
) (
    input  logic       clock_25,
    input  logic       reset_n,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       line_start
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam coord_t H_VIS_C      = coord_t'(H_VIS);
    localparam coord_t V_VIS_C      = coord_t'(V_VIS);
    localparam coord_t H_SYNC_START = coord_t'(H_VIS + H_FP);
    localparam coord_t H_SYNC_END   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t V_SYNC_START = coord_t'(V_VIS + V_FP);
    localparam coord_t V_SYNC_END   = coord_t'(V_VIS + V_FP + V_SYNC);

    coord_t h_cnt_s;
    coord_t h_next_s;
    logic   h_wrap_s;
    coord_t v_cnt_s;
    coord_t v_next_s;
    logic   v_wrap_s;

    logic video_on_next_s;
    logic frame_start_next_s;
    logic line_start_next_s;
    logic hsync_int_s;
    logic vsync_int_s;

    logic video_on_r;
    logic frame_start_r;
    logic line_start_r;
    logic hsync_r;
    logic vsync_r;

    mod_counter #(
        .MOD  (H_TOT),
        .W    (CNT_W),
        .INIT (H_TOT - 1)
    ) u_h_cnt (
        .clk        (clock_25),
        .rst_n      (reset_n),
        .en         (1'b1),
        .count      (h_cnt_s),
        .count_next (h_next_s),
        .wrap       (h_wrap_s)
    );

    // Vertical wraps on the same edge as the horizontal wrap that carries into it.
    mod_counter #(
        .MOD  (V_TOT),
        .W    (CNT_W),
        .INIT (V_TOT - 1)
    ) u_v_cnt (
        .clk        (clock_25),
        .rst_n      (reset_n),
        .en         (h_wrap_s),
        .count      (v_cnt_s),
        .count_next (v_next_s),
        .wrap       (v_wrap_s)
    );

    // Flags decoded from next counter values so the registered copies track pix_x/pix_y.
    always_comb begin
        video_on_next_s    = 1'b0;
        frame_start_next_s = 1'b0;
        line_start_next_s  = 1'b0;
        hsync_int_s        = 1'b1;
        vsync_int_s        = 1'b1;
        video_on_next_s    = (h_next_s < H_VIS_C) && (v_next_s < V_VIS_C);
        line_start_next_s  = (h_next_s == coord_t'(0));
        frame_start_next_s = (h_next_s == coord_t'(0)) && (v_next_s == coord_t'(0));
        hsync_int_s        = ~in_window(h_cnt_s, H_SYNC_START, H_SYNC_END);
        vsync_int_s        = ~in_window(v_cnt_s, V_SYNC_START, V_SYNC_END);
    end

    // Output registers; sync is the current-count decode, hence one clock late.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
        end else begin
            video_on_r    <= video_on_next_s;
            frame_start_r <= frame_start_next_s;
            line_start_r  <= line_start_next_s;
            hsync_r       <= hsync_int_s;
            vsync_r       <= vsync_int_s;
        end
    end

    assign pix_x       = h_cnt_s;
    assign pix_y       = v_cnt_s;
    assign video_on    = video_on_r;
    assign frame_start = frame_start_r;
    assign line_start  = line_start_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;

    // The vertical wrap strobe is not needed beyond the counter itself.
    logic unused_s;
    assign unused_s = v_wrap_s;

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: scoreboarded reduced-timing instance
// plus line-level checks of a default-timing instance.
module tb_vga_sync;

    localparam int HV = 8, HF = 1, HS = 2, HB = 1;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic clk;
    logic s_rst_n, b_rst_n;

    logic [9:0] s_pix_x, s_pix_y, b_pix_x, b_pix_y;
    logic s_vo, s_hs, s_vs, s_fs, s_ls;
    logic b_vo, b_hs, b_vs, b_fs, b_ls;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic vo, hs, vs, fs, ls;
    } exp_t;

    exp_t sb_q[$];
    int   mx, my;
    int   n_vec = 0;
    int   n_err = 0;

    vga_sync #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut_small (
        .clock_25(clk), .reset_n(s_rst_n),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .video_on(s_vo),
        .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs), .line_start(s_ls)
    );

    vga_sync u_dut_big (
        .clock_25(clk), .reset_n(b_rst_n),
        .pix_x(b_pix_x), .pix_y(b_pix_y), .video_on(b_vo),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .line_start(b_ls)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model for the small instance: expectation after the coming edge.
    task automatic model_push();
        exp_t e;
        if (!s_rst_n) begin
            mx = HT - 1; my = VT - 1;
            e.hs = 1'b1; e.vs = 1'b1; e.vo = 1'b0; e.fs = 1'b0; e.ls = 1'b0;
        end else begin
            e.hs = !((mx >= HV + HF) && (mx < HV + HF + HS));
            e.vs = !((my >= VV + VF) && (my < VV + VF + VS));
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            e.vo = (mx < HV) && (my < VV);
            e.fs = (mx == 0) && (my == 0);
            e.ls = (mx == 0);
        end
        e.x = 10'(mx);
        e.y = 10'(my);
        sb_q.push_back(e);
    endtask

    // One clock: push expectation, wait to the falling edge, compare small instance.
    task automatic tick();
        exp_t e;
        model_push();
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq("sb_pix_x", 32'(s_pix_x), 32'(e.x));
        check_eq("sb_pix_y", 32'(s_pix_y), 32'(e.y));
        check_eq("sb_video_on", 32'(s_vo), 32'(e.vo));
        check_eq("sb_hsync", 32'(s_hs), 32'(e.hs));
        check_eq("sb_vsync", 32'(s_vs), 32'(e.vs));
        check_eq("sb_frame_start", 32'(s_fs), 32'(e.fs));
        check_eq("sb_line_start", 32'(s_ls), 32'(e.ls));
    endtask

    task automatic wait_small(input int x, input int y, input int limit, input string tag);
        int n = 0;
        while (!((s_pix_x == 10'(x)) && (s_pix_y == 10'(y))) && (n < limit)) begin
            tick();
            n++;
        end
        check_eq(tag, 32'((s_pix_x == 10'(x)) && (s_pix_y == 10'(y))), 32'd1);
    endtask

    initial begin
        int cnt_vo, cnt_hs, cnt_vs, cnt_ls, cnt_fs, first_low_x, n;
        s_rst_n = 1'b0;
        b_rst_n = 1'b0;
        mx = 0; my = 0;
        repeat (3) tick();

        // Default timing: reset values.
        check_eq("big_rst_x", 32'(b_pix_x), 32'd799);
        check_eq("big_rst_y", 32'(b_pix_y), 32'd524);
        check_eq("big_rst_vo", 32'(b_vo), 32'd0);
        check_eq("big_rst_hs", 32'(b_hs), 32'd1);
        check_eq("big_rst_vs", 32'(b_vs), 32'd1);
        check_eq("big_rst_fs", 32'(b_fs), 32'd0);
        check_eq("big_rst_ls", 32'(b_ls), 32'd0);

        // Default timing: first edge and one full line.
        b_rst_n = 1'b1;
        tick();
        check_eq("big_first_x", 32'(b_pix_x), 32'd0);
        check_eq("big_first_y", 32'(b_pix_y), 32'd0);
        check_eq("big_first_vo", 32'(b_vo), 32'd1);
        check_eq("big_first_fs", 32'(b_fs), 32'd1);
        check_eq("big_first_ls", 32'(b_ls), 32'd1);
        cnt_vo = 0; cnt_hs = 0; cnt_ls = 0; first_low_x = -1;
        for (int k = 0; k < 800; k++) begin
            check_eq("big_line_x", 32'(b_pix_x), 32'(k));
            cnt_vo += int'(b_vo);
            cnt_ls += int'(b_ls);
            if (!b_hs) begin
                cnt_hs++;
                if (first_low_x < 0) first_low_x = int'(b_pix_x);
            end
            tick();
        end
        check_eq("big_vo_high", 32'(cnt_vo), 32'd640);
        check_eq("big_hs_low", 32'(cnt_hs), 32'd96);
        check_eq("big_hs_first_low_x", 32'(first_low_x), 32'd657);
        check_eq("big_ls_per_line", 32'(cnt_ls), 32'd1);
        check_eq("big_line2_x", 32'(b_pix_x), 32'd0);
        check_eq("big_line2_y", 32'(b_pix_y), 32'd1);
        check_eq("big_line2_fs", 32'(b_fs), 32'd0);
        check_eq("big_line2_ls", 32'(b_ls), 32'd1);
        check_eq("big_line2_vs", 32'(b_vs), 32'd1);
        b_rst_n = 1'b0;

        // Reduced timing: release and measure one frame between frame_start pulses.
        s_rst_n = 1'b1;
        tick();
        check_eq("sm_first_fs", 32'(s_fs), 32'd1);
        cnt_vo = 0; cnt_hs = 0; cnt_vs = 0; cnt_ls = 0; cnt_fs = 0;
        for (int k = 0; k < HT * VT; k++) begin
            cnt_vo += int'(s_vo);
            cnt_hs += int'(!s_hs);
            cnt_vs += int'(!s_vs);
            cnt_ls += int'(s_ls);
            cnt_fs += int'(s_fs);
            tick();
        end
        check_eq("sm_frame_period", 32'(s_fs), 32'd1);
        check_eq("sm_fs_per_frame", 32'(cnt_fs), 32'd1);
        check_eq("sm_vo_per_frame", 32'(cnt_vo), 32'(HV * VV));
        check_eq("sm_hs_low", 32'(cnt_hs), 32'(HS * VT));
        check_eq("sm_vs_low", 32'(cnt_vs), 32'(VS * HT));
        check_eq("sm_ls_per_frame", 32'(cnt_ls), 32'(VT));

        // Boundaries: last visible line to first blank line, and frame wrap.
        wait_small(HT - 1, VV - 1, 200, "sm_reach_last_vis");
        tick();
        check_eq("sm_blank_x", 32'(s_pix_x), 32'd0);
        check_eq("sm_blank_y", 32'(s_pix_y), 32'(VV));
        check_eq("sm_blank_vo", 32'(s_vo), 32'd0);
        wait_small(HT - 1, VT - 1, 200, "sm_reach_frame_end");
        tick();
        check_eq("sm_wrap_x", 32'(s_pix_x), 32'd0);
        check_eq("sm_wrap_y", 32'(s_pix_y), 32'd0);

        // Mid-frame reset inside both sync pulses: forced asynchronously.
        wait_small(HV + HF + 1, VV + VF, 200, "sm_reach_rst_point");
        check_eq("sm_pre_rst_hs", 32'(s_hs), 32'd0);
        check_eq("sm_pre_rst_vs", 32'(s_vs), 32'd0);
        #5 s_rst_n = 1'b0;
        #1;
        check_eq("sm_async_x", 32'(s_pix_x), 32'(HT - 1));
        check_eq("sm_async_y", 32'(s_pix_y), 32'(VT - 1));
        check_eq("sm_async_vo", 32'(s_vo), 32'd0);
        check_eq("sm_async_hs", 32'(s_hs), 32'd1);
        check_eq("sm_async_vs", 32'(s_vs), 32'd1);
        check_eq("sm_async_fs", 32'(s_fs), 32'd0);
        check_eq("sm_async_ls", 32'(s_ls), 32'd0);
        repeat (3) tick();
        s_rst_n = 1'b1;
        tick();
        check_eq("sm_restart_x", 32'(s_pix_x), 32'd0);
        check_eq("sm_restart_y", 32'(s_pix_y), 32'd0);
        check_eq("sm_restart_fs", 32'(s_fs), 32'd1);
        n = 0;
        repeat (2 * HT * VT) begin
            tick();
            n++;
        end
        check_eq("sm_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_VIS, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 Parameter V_VIS, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Port clock_25 input 1: the one clock, 25 MHz pixel clock.
REQ-010 Port reset_n input 1: reset, asynchronous, active-low.
REQ-011 Port pix_x output 10: current pixel column.
REQ-012 Port pix_y output 10: current pixel line.
REQ-013 Port video_on output 1: high when (pix_x, pix_y) is visible.
REQ-014 Port hsync output 1: horizontal sync, active-low, one cycle late relative to pix_x.
REQ-015 Port vsync output 1: vertical sync, active-low, one cycle late relative to pix_y.
REQ-016 Port frame_start output 1: one-cycle pulse while (pix_x, pix_y) = (0, 0).
REQ-017 Port line_start output 1: one-cycle pulse while pix_x = 0.

Function
REQ-018 H_TOT = H_VIS+H_FP+H_SYNC+H_BP (default 800) and V_TOT = V_VIS+V_FP+V_SYNC+V_BP (default 525) SHALL be derived constants.
REQ-019 pix_x SHALL increment by 1 every clock and wrap from H_TOT-1 to 0.
REQ-020 pix_y SHALL increment by 1 only on the cycle pix_x wraps; it wraps from V_TOT-1 to 0 on the same edge on which pix_x wraps.
REQ-021 pix_x and pix_y SHALL never leave the ranges 0..H_TOT-1 and 0..V_TOT-1.
REQ-022 video_on, frame_start and line_start SHALL be registered: computed from the next counter values so they match the current pix_x/pix_y in every cycle.
REQ-023 video_on SHALL be 1 exactly when pix_x < H_VIS and pix_y < V_VIS.
REQ-024 Internal hsync timing: low when H_VIS+H_FP <= pix_x < H_VIS+H_FP+H_SYNC (656..751); the port hsync SHALL be this value delayed one clock.
REQ-025 Internal vsync timing: low when V_VIS+V_FP <= pix_y < V_VIS+V_FP+V_SYNC (490..491); the port vsync SHALL be this value delayed one clock.
REQ-026 The one-clock sync delay SHALL match the registered colour stage of the pixel generator, so sync and RGB leave aligned.
REQ-027 There SHALL be no combinational path from any input to any output except reset_n.

Reset
REQ-028 While reset_n = 0: pix_x = H_TOT-1, pix_y = V_TOT-1, video_on = 0, hsync = 1, vsync = 1, frame_start = 0, line_start = 0.
REQ-029 On the first rising edge after reset_n rises: pix_x = 0, pix_y = 0, video_on = 1, frame_start = 1, line_start = 1.
REQ-030 Asserting reset_n mid-frame SHALL immediately force the REQ-028 values, with no partial sync pulse held.

Structure
REQ-031 Timing defaults and derived totals SHALL live in shared package vga_timing_pkg, also used by the graphics block for MAX_X/MAX_Y.
REQ-032 One sub-module, mod_counter (parameterised modulus, enable in, wrap out), SHALL be instantiated twice: the horizontal one always enabled, the vertical one enabled by the horizontal wrap.

Verification
REQ-033 Release reset -> first edge gives pix=(0,0), video_on=1, frame_start=1; frame_start next high exactly 420000 clocks later.
REQ-034 Watch one line -> video_on high for 640 clocks and low for 160; hsync low for 96 clocks, first low the cycle after pix_x=656.
REQ-035 Watch one frame -> vsync low for 1600 clocks (lines 490-491, delayed one clock); line_start count = 525.
REQ-036 At pix=(799,524) -> next edge gives (0,0); at pix=(799,479) -> next edge gives (0,480) with video_on=0.
REQ-037 Assert reset_n at pix=(700,490) for 3 clocks -> all outputs take REQ-028 values asynchronously; the sequence restarts per REQ-029.
REQ-038 Override H_VIS=8, H_FP=1, H_SYNC=2, H_BP=1, V_VIS=4, V_FP=1, V_SYNC=1, V_BP=1 -> frame period of 84 clocks; pulse widths scale accordingly.
